// File: rtl/car_detector_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : car_detector_conditioner_if
// Brief    : Sensor/request bundle between the loop conditioner and its users.
// Revision : 1.0 - initial release
// ============================================================================
interface car_detector_conditioner_if #(
    parameter int COUNT_W = 8
);
    logic               loop_raw;
    logic               count_clear;
    logic               car;
    logic               car_arrive;
    logic [COUNT_W-1:0] car_count;
    logic               fault;

    modport master (
        output loop_raw,
        output count_clear,
        input  car,
        input  car_arrive,
        input  car_count,
        input  fault
    );

    modport slave (
        input  loop_raw,
        input  count_clear,
        output car,
        output car_arrive,
        output car_count,
        output fault
    );
endinterface
`default_nettype wire

// File: rtl/car_detector_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : car_detector_conditioner
// Brief    : Synchronises, debounces and counts the farm-road loop; blanks a stuck loop.
// Revision : 1.0 - initial release
// ============================================================================
module car_detector_conditioner #(
    parameter int DEBOUNCE    = 3,
    parameter int STUCK_LIMIT = 64,
    parameter int COUNT_W     = 8
) (
    input  wire logic                      clk,
    input  wire logic                      reset,
    car_detector_conditioner_if.slave      bus
);

    typedef enum logic [2:0] {
        ST_ABSENT   = 3'd0,
        ST_ARRIVING = 3'd1,
        ST_PRESENT  = 3'd2,
        ST_LEAVING  = 3'd3,
        ST_STUCK    = 3'd4
    } state_t;

    localparam logic [3:0] C_DB_LAST = 4'(DEBOUNCE - 1);
    localparam logic [9:0] C_STUCK   = 10'(STUCK_LIMIT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_s1;
    logic               r_s;
    logic [3:0]         r_dcnt;
    logic [3:0]         w_dcnt_nxt;
    logic [9:0]         r_scnt;
    logic [9:0]         w_scnt_nxt;
    logic [9:0]         w_scnt_inc;
    logic               w_arrive;
    logic               r_car;
    logic               r_arrive;
    logic               r_fault;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_count_inc;
    logic [COUNT_W-1:0] w_count_nxt;

    // Stuck counter runs from acceptance through any dips, saturating at the limit.
    assign w_scnt_inc = (r_scnt >= C_STUCK) ? r_scnt : r_scnt + 10'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_scnt_nxt  = r_scnt;
        w_arrive    = 1'b0;
        case (r_state)
            ST_ABSENT: begin
                if (r_s) begin
                    if (DEBOUNCE == 1) begin
                        w_state_nxt = ST_PRESENT;
                        w_arrive    = 1'b1;
                        w_scnt_nxt  = 10'd1;
                    end else begin
                        w_state_nxt = ST_ARRIVING;
                        w_dcnt_nxt  = 4'd1;
                    end
                end
            end
            ST_ARRIVING: begin
                if (!r_s) begin
                    w_state_nxt = ST_ABSENT;
                    w_dcnt_nxt  = 4'd0;
                end else if (r_dcnt == C_DB_LAST) begin
                    w_state_nxt = ST_PRESENT;
                    w_arrive    = 1'b1;
                    w_scnt_nxt  = 10'd1;
                    w_dcnt_nxt  = 4'd0;
                end else begin
                    w_dcnt_nxt  = r_dcnt + 4'd1;
                end
            end
            ST_PRESENT: begin
                w_scnt_nxt = w_scnt_inc;
                if (!r_s) begin
                    if (DEBOUNCE == 1) begin
                        w_state_nxt = ST_ABSENT;
                        w_scnt_nxt  = 10'd0;
                    end else begin
                        w_state_nxt = ST_LEAVING;
                        w_dcnt_nxt  = 4'd1;
                    end
                end else if (r_scnt >= C_STUCK) begin
                    w_state_nxt = ST_STUCK;
                    w_dcnt_nxt  = 4'd0;
                end
            end
            ST_LEAVING: begin
                w_scnt_nxt = w_scnt_inc;
                if (r_s) begin
                    w_state_nxt = ST_PRESENT;
                    w_dcnt_nxt  = 4'd0;
                end else if (r_dcnt == C_DB_LAST) begin
                    w_state_nxt = ST_ABSENT;
                    w_dcnt_nxt  = 4'd0;
                    w_scnt_nxt  = 10'd0;
                end else begin
                    w_dcnt_nxt  = r_dcnt + 4'd1;
                end
            end
            ST_STUCK: begin
                // Any high sample restarts the quiet run needed to clear the fault.
                if (r_s) begin
                    w_dcnt_nxt  = 4'd0;
                end else if (r_dcnt == C_DB_LAST) begin
                    w_state_nxt = ST_ABSENT;
                    w_dcnt_nxt  = 4'd0;
                    w_scnt_nxt  = 10'd0;
                end else begin
                    w_dcnt_nxt  = r_dcnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_ABSENT;
                w_dcnt_nxt  = 4'd0;
                w_scnt_nxt  = 10'd0;
            end
        endcase
    end

    assign w_count_inc = (w_arrive && (r_count != {COUNT_W{1'b1}})) ? r_count + COUNT_W'(1) : r_count;
    assign w_count_nxt = bus.count_clear ? (w_arrive ? COUNT_W'(1) : '0) : w_count_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1     <= 1'b0;
            r_s      <= 1'b0;
            r_state  <= ST_ABSENT;
            r_dcnt   <= 4'd0;
            r_scnt   <= 10'd0;
            r_car    <= 1'b0;
            r_arrive <= 1'b0;
            r_fault  <= 1'b0;
            r_count  <= '0;
        end else begin
            r_s1     <= bus.loop_raw;
            r_s      <= r_s1;
            r_state  <= w_state_nxt;
            r_dcnt   <= w_dcnt_nxt;
            r_scnt   <= w_scnt_nxt;
            r_car    <= (w_state_nxt == ST_PRESENT) || (w_state_nxt == ST_LEAVING);
            r_arrive <= w_arrive;
            r_fault  <= (w_state_nxt == ST_STUCK);
            r_count  <= w_count_nxt;
        end
    end

    assign bus.car        = r_car;
    assign bus.car_arrive = r_arrive;
    assign bus.car_count  = r_count;
    assign bus.fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_car_detector_conditioner.sv
`default_nettype none
// Scoreboard bench: stimulus queues hand-timed output changes, a monitor
// checks every observed change of the outputs against the queue head.
module tb_car_detector_conditioner;

    typedef struct {
        int         at;
        logic       car;
        logic       arr;
        logic       flt;
        logic [7:0] cnt;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    ev_t  q[$];

    car_detector_conditioner_if #(.COUNT_W(8)) bus();

    car_detector_conditioner #(
        .DEBOUNCE    (3),
        .STUCK_LIMIT (64),
        .COUNT_W     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int at, input logic car, input logic arr, input int cnt, input logic flt);
        ev_t e;
        e.at  = at;
        e.car = car;
        e.arr = arr;
        e.flt = flt;
        e.cnt = 8'(cnt);
        q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic car, input logic arr, input int cnt, input logic flt);
        n_vec++;
        if (bus.car !== car || bus.car_arrive !== arr || bus.fault !== flt || bus.car_count !== 8'(cnt)) begin
            n_err++;
            $display("FAIL %s: got car=%b arr=%b cnt=%0d flt=%b, need car=%b arr=%b cnt=%0d flt=%b",
                     name, bus.car, bus.car_arrive, bus.car_count, bus.fault, car, arr, cnt, flt);
        end
    endtask

    task automatic drive(input logic v, input int n);
        bus.loop_raw = v;
        repeat (n) @(negedge clk);
    endtask

    // One clean arrival: 5 high samples then 6 low; optional clear on the accept edge.
    task automatic arrival(input logic clr, input int exp_cnt);
        int t0;
        t0 = cyc + 1;
        push(t0 + 4, 1'b1, 1'b1, exp_cnt, 1'b0);
        push(t0 + 5, 1'b1, 1'b0, exp_cnt, 1'b0);
        push(t0 + 9, 1'b0, 1'b0, exp_cnt, 1'b0);
        bus.loop_raw = 1'b1;
        repeat (4) @(negedge clk);
        bus.count_clear = clr;
        @(negedge clk);
        bus.count_clear = 1'b0;
        bus.loop_raw    = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Monitor
    initial begin : mon
        logic [10:0] prev;
        logic [10:0] cur;
        ev_t         e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {bus.car, bus.car_arrive, bus.fault, bus.car_count};
            if (mon_en && cur !== prev) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_change@%0d: got car=%b arr=%b cnt=%0d flt=%b, need no change",
                             cyc, bus.car, bus.car_arrive, bus.car_count, bus.fault);
                end else begin
                    e = q.pop_front();
                    if (e.at != cyc || bus.car !== e.car || bus.car_arrive !== e.arr ||
                        bus.fault !== e.flt || bus.car_count !== e.cnt) begin
                        n_err++;
                        $display("FAIL event: got cyc=%0d car=%b arr=%b cnt=%0d flt=%b, need cyc=%0d car=%b arr=%b cnt=%0d flt=%b",
                                 cyc, bus.car, bus.car_arrive, bus.car_count, bus.fault,
                                 e.at, e.car, e.arr, e.cnt, e.flt);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int t0;
        int f0;
        bus.loop_raw    = 1'b0;
        bus.count_clear = 1'b0;
        repeat (3) @(negedge clk);
        check_now("reset_state", 1'b0, 1'b0, 0, 1'b0);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // Short glitches are rejected
        drive(1'b1, 1); drive(1'b0, 6);
        drive(1'b1, 2); drive(1'b0, 6);
        check_now("glitch_reject", 1'b0, 1'b0, 0, 1'b0);

        // Held presence: accept at E0+4, release at F0+4
        t0 = cyc + 1;
        push(t0 + 4, 1'b1, 1'b1, 1, 1'b0);
        push(t0 + 5, 1'b1, 1'b0, 1, 1'b0);
        drive(1'b1, 10);
        check_now("held_present", 1'b1, 1'b0, 1, 1'b0);
        f0 = cyc + 1;
        push(f0 + 4, 1'b0, 1'b0, 1, 1'b0);
        drive(1'b0, 8);

        // Dip of 2 ignored, then a 5+ cycle release
        t0 = cyc + 1;
        push(t0 + 4, 1'b1, 1'b1, 2, 1'b0);
        push(t0 + 5, 1'b1, 1'b0, 2, 1'b0);
        drive(1'b1, 8);
        drive(1'b0, 2);
        drive(1'b1, 8);
        check_now("dip_held", 1'b1, 1'b0, 2, 1'b0);
        f0 = cyc + 1;
        push(f0 + 4, 1'b0, 1'b0, 2, 1'b0);
        drive(1'b0, 10);

        // Stuck loop: fault 64 cycles after car rose, clears after 3 quiet samples
        t0 = cyc + 1;
        push(t0 + 4,  1'b1, 1'b1, 3, 1'b0);
        push(t0 + 5,  1'b1, 1'b0, 3, 1'b0);
        push(t0 + 68, 1'b0, 1'b0, 3, 1'b1);
        drive(1'b1, 100);
        check_now("stuck_fault", 1'b0, 1'b0, 3, 1'b1);
        f0 = cyc + 1;
        push(f0 + 4, 1'b0, 1'b0, 3, 1'b0);
        drive(1'b0, 8);

        // count_clear alone, then saturation
        push(cyc + 1, 1'b0, 1'b0, 0, 1'b0);
        bus.count_clear = 1'b1;
        @(negedge clk);
        bus.count_clear = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 256; i++) arrival(1'b0, (i > 255) ? 255 : i);
        check_now("saturated", 1'b0, 1'b0, 255, 1'b0);
        arrival(1'b1, 1);

        // Reset in ARRIVING with dcnt=2; timing restarts afterwards
        t0 = cyc + 1;
        bus.loop_raw = 1'b1;
        repeat (4) @(negedge clk);
        push(cyc + 1, 1'b0, 1'b0, 0, 1'b0);
        #2 reset = 1'b1;
        #1 check_now("reset_arriving", 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        t0 = cyc + 1;
        push(t0 + 4,  1'b1, 1'b1, 1, 1'b0);
        push(t0 + 5,  1'b1, 1'b0, 1, 1'b0);
        push(t0 + 68, 1'b0, 1'b0, 1, 1'b1);
        drive(1'b1, 72);

        // Reset while faulted
        push(cyc + 1, 1'b0, 1'b0, 0, 1'b0);
        #2 reset = 1'b1;
        #1 check_now("reset_fault", 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 8);

        while (q.size() > 0) begin
            ev_t e;
            e = q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_event: got none, need cyc=%0d car=%b arr=%b cnt=%0d flt=%b",
                     e.at, e.car, e.arr, e.cnt, e.flt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/car_detector_conditioner.md
# car_detector_conditioner

Conditions the raw farm-road inductive-loop signal into the clean `car` request consumed by the traffic light controller. It synchronises the asynchronous sensor, debounces it in both directions, counts arrivals, and detects a stuck-high loop. On a stuck loop it forces `car` low so the highway stays green. It sits directly upstream of the controller, on the same clock and reset.

## Interface
- `DEBOUNCE`, 3: consecutive synchronised cycles required to accept a level change; legal range 1–15.
- `STUCK_LIMIT`, 64: consecutive cycles of accepted presence before the loop is declared faulty; must be greater than `DEBOUNCE`; legal range up to 1023.
- `COUNT_W`, 8: width of the arrival counter.
- `clk` input 1: single system clock; all logic is rising-edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `loop_raw` input 1: raw loop sensor, asynchronous to `clk`.
- `count_clear` input 1: synchronous; clears `car_count`.
- `car` output 1: registered, debounced presence to the controller.
- `car_arrive` output 1: registered one-cycle pulse per accepted arrival.
- `car_count` output `COUNT_W`: saturating arrival count.
- `fault` output 1: registered stuck-loop flag.

## Operation
- Synchroniser: two flops, `loop_raw` → `s1` → `s`. The FSM uses only `s`.
- Reset values: `s1`=0, `s`=0; state ABSENT; counters 0; `car`=0, `car_arrive`=0, `car_count`=0, `fault`=0.
- Reset asserted mid-operation: everything returns to these values immediately (asynchronously). Any partial debounce is discarded.
- `dcnt`: debounce counter. `scnt`: stuck counter.
- ABSENT:
  - `s`=1 → ARRIVING, `dcnt`=1.
  - With `DEBOUNCE`=1 it goes straight to PRESENT (same actions as the ARRIVING→PRESENT transition).
- ARRIVING:
  - `s`=0 → ABSENT (glitch rejected, no count).
  - `s`=1 and `dcnt`=`DEBOUNCE`−1 → PRESENT: `car`←1, `car_arrive`←1 for one cycle, `car_count` increments, `scnt`=1.
  - Otherwise `dcnt`++.
- PRESENT:
  - `s`=0 → LEAVING, `dcnt`=1.
  - `s`=1 → `scnt`++; when `scnt` reaches `STUCK_LIMIT` → STUCK.
- LEAVING:
  - `s`=1 → PRESENT; `scnt` keeps counting and is not restarted.
  - `s`=0 for `DEBOUNCE` consecutive cycles → ABSENT, `car`←0.
  - `scnt` increments in LEAVING as well.
- STUCK:
  - On entry: `car`←0, `fault`←1.
  - Exit only after `s`=0 for `DEBOUNCE` consecutive cycles → ABSENT, `fault`←0.
  - Any `s`=1 restarts that run. No arrival is counted on exit.
- `car_count`:
  - Saturates at 2^`COUNT_W`−1; no wrap.
  - `count_clear` alone → 0.
  - `count_clear` coincident with an increment → 1.
- `car` is 1 only in PRESENT and LEAVING. `car` and `fault` are never 1 together.

## Timing
- Let E0 be the first rising edge sampling `loop_raw`=1.
  - `s`=1 after E1.
  - `car` and `car_arrive` rise after edge E0+`DEBOUNCE`+1 (E4 at defaults).
- Release uses the same timing: `car` falls `DEBOUNCE`+1 edges after the first edge sampling 0.
- Stuck: `fault` rises and `car` falls `STUCK_LIMIT` cycles after `car` rose, if `s` never produced an accepted release.
- All outputs are registered; there is no combinational path from any input to any output.
- Controller interaction: `car` changes at most once per `DEBOUNCE` cycles, so the controller never sees a single-cycle glitch.

## Test plan
1. Reset, then hold `loop_raw`=1 from edge E0 → `car`=1 and one `car_arrive` pulse after E4; `car_count`=1; `fault`=0.
2. Pulses of 1 and 2 cycles on `loop_raw` with the line otherwise 0 → `car` stays 0; `car_count` stays 0.
3. While `car`=1, a 2-cycle low dip → `car` stays 1, no new count. A 5-cycle low → `car` falls 4 edges after the first low sample.
4. Hold `loop_raw`=1 for 100 cycles → `car` rises after E4 and falls with `fault`=1 at 64 cycles later. Then release for 3+ cycles → `fault`=0 and `car_count` is still 1.
5. 256 clean arrivals with `COUNT_W`=8 → `car_count`=255 saturated. `count_clear` on the cycle of a 257th acceptance → `car_count`=1.
6. Assert `reset` in ARRIVING (`dcnt`=2) and again while `fault`=1 → all outputs 0 immediately. After reset, arrival timing restarts from the beginning.
